dac_playback_driver: RTL
========================

Name: dac_playback_driver

Overview:
- PS-to-DAC counterpart of the ADC capture path.
- Accepts 32-bit AXIS words from the CPU and packs four words into each 128-bit sample beat.
- Stores beats in an internal waveform buffer.
- On a GPIO trigger, replays the buffer to the RF-DAC AXIS input, once or looped. The DAC stream stays continuously valid.

Parameters:
- MEM_WIDTH, 16, log2 of buffer depth in 128-bit beats.
- PS_WIDTH, 32, PS AXIS data width; must be exactly 32.
- DAC_WIDTH, 128, DAC AXIS data width; must be exactly 4×PS_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous reset, active-low.
- gpio_ctrl_ext  in  16  control word from the RFSoC control block; registered once internally.
- s_axis_tdata  in  32  PS write data; word 0 maps to bits [31:0].
- s_axis_tvalid  in  1  PS data valid.
- s_axis_tready  out  1  ready to accept PS data.
- m_axis_tdata  out  128  DAC sample beat.
- m_axis_tvalid  out  1  DAC data valid.
- m_axis_tready  in  1  DAC ready; ignored, because the DAC consumes every cycle.
- select_in  in  1  channel select, same meaning as the ADC path; trigger is honoured only when select_in=1.
- playing  out  1  high while in PLAY.
- beat_count  out  MEM_WIDTH+1  number of beats loaded.

Behaviour:
- Reset (rst=0): asynchronous reset to IDLE.
  - s_axis_tready=0, m_axis_tdata=0, m_axis_tvalid=1, playing=0, beat_count=0.
  - Pack index, write pointer and read pointer cleared.
  - Buffer contents undefined.
- gpio_ctrl = gpio_ctrl_ext registered. Bit positions come from the package: GPIO_DAC_TRIGGER, GPIO_DAC_FLUSH, GPIO_DAC_LOAD, GPIO_DAC_LOOP.
- Trigger is the rising edge of gpio_ctrl[GPIO_DAC_TRIGGER], detected with a second register. First PLAY beat appears 3 cycles after gpio_ctrl_ext rises:
  - 1 cycle sync,
  - 1 cycle edge,
  - 1 cycle RAM read.
- IDLE:
  - s_axis_tready=0; output holds the idle value.
  - gpio_ctrl[GPIO_DAC_LOAD]=1 → LOAD; clears write pointer, pack index and beat_count.
  - Trigger with select_in=1 and beat_count>0 → PLAY.
  - Trigger with beat_count=0 is ignored.
- LOAD:
  - s_axis_tready=1 while not full.
  - Each handshake stores the word into pack lane idx (0..3).
  - At idx=3 the assembled beat is written to RAM[wr_ptr]; wr_ptr and beat_count increment.
  - Full (beat_count=2^MEM_WIDTH): tready=0 and further words are stalled.
  - LOAD deasserted → IDLE. A partial beat (idx≠0) is discarded and idx is cleared.
  - Triggers are ignored in LOAD.
- PLAY:
  - rd_ptr advances by one every cycle; m_axis_tdata = RAM[rd_ptr] with 1-cycle read latency.
  - After beat beat_count-1 is output:
    - if GPIO_DAC_LOOP=1, wrap to 0 with no gap cycle;
    - otherwise → IDLE.
  - A new trigger during PLAY restarts playback from beat 0.
- Flush (gpio_ctrl[GPIO_DAC_FLUSH]=1) has priority over all other inputs, in any state:
  - → IDLE; beat_count=0; output = idle value; tready=0.
- Simultaneous LOAD and trigger in IDLE: LOAD wins.
- m_axis_tvalid is always 1 out of reset, and m_axis_tready is not consulted.
- Arithmetic: pointers are MEM_WIDTH bits; beat_count is MEM_WIDTH+1 bits so that full is representable.

Optional Feature:
- DAC_HOLD_LAST_EN defined: after non-looped playback ends, the output holds the last played beat until flush, reset or a new trigger.
- Undefined: the output returns to 128'h0 on the first cycle after the final beat.

Decomposition:
- Add to the shared rfsoc_config package:
  - GPIO_DAC_TRIGGER, GPIO_DAC_FLUSH, GPIO_DAC_LOAD, GPIO_DAC_LOOP bit indices;
  - dac_state_t enum {IDLE, LOAD, PLAY}.
- One sub-module: dac_wave_ram.
  - Simple dual-port, 2^MEM_WIDTH × 128.
  - Registered read, one write port, same clock.

Test Plan:
1. Reset mid-PLAY: rst low for 1 cycle → m_axis_tdata=0, playing=0, beat_count=0 immediately, without waiting for a clock edge.
2. Load 8 words 0x00..0x07, then trigger with loop off → two beats 0x00000003_00000002_00000001_00000000 and 0x…07_06_05_04, starting 3 cycles after the trigger; then zeros; playing falls.
3. Loop on, 3 beats loaded → output sequence B0,B1,B2,B0,B1… with no gap cycle; a second trigger mid-stream restarts at B0.
4. MEM_WIDTH=2, load 20 words → tready deasserts after word 16; beat_count=4; extra words remain stalled.
5. LOAD deasserted after 6 words → beat_count=1; the partial beat is discarded; playback emits exactly 1 beat.
6. Trigger with select_in=0 or beat_count=0 → no playback. Flush asserted during PLAY → idle output next cycle and beat_count=0.

Source files
------------

// File: rtl/rfsoc_config_pkg.sv
// Shared RFSoC configuration: GPIO control-word bit positions and DAC playback states.
package rfsoc_config;

  localparam int GPIO_DAC_TRIGGER = 0;
  localparam int GPIO_DAC_FLUSH   = 1;
  localparam int GPIO_DAC_LOAD    = 2;
  localparam int GPIO_DAC_LOOP    = 3;

  localparam int DAC_LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY
  } dac_state_t;

endpackage

// File: rtl/dac_wave_ram.sv
// Simple dual-port waveform buffer: one write port, one registered read port, single clock.
module dac_wave_ram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // rd_data only changes on an enabled read, so it also serves as the hold-last register
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dac_playback_driver.sv
// PS-to-DAC playback: packs 32-bit PS words into 128-bit beats, buffers them, replays on trigger.
// Optional build macro DAC_HOLD_LAST_EN: hold the last played beat after non-looped playback.
module dac_playback_driver
  import rfsoc_config::*;
#(
  parameter int MEM_WIDTH = 16,
  parameter int PS_WIDTH  = 32,
  parameter int DAC_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          gpio_ctrl_ext,
  input  logic [PS_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [DAC_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 select_in,
  output logic                 playing,
  output logic [MEM_WIDTH:0]   beat_count
);

  localparam logic [MEM_WIDTH:0]   FULL_COUNT = {1'b1, {MEM_WIDTH{1'b0}}};
  localparam logic [MEM_WIDTH:0]   COUNT_ONE  = {{MEM_WIDTH{1'b0}}, 1'b1};
  localparam logic [MEM_WIDTH-1:0] PTR_ONE    = {{(MEM_WIDTH-1){1'b0}}, 1'b1};

  dac_state_t state, next_state;

  logic [15:0]                 gpio_ctrl;
  logic                        trig_prev, trig_q;
  logic                        flush, load_bit, loop_bit, fire, full, handshake, wr_en;
  logic [MEM_WIDTH-1:0]        wr_ptr, rd_ptr, rd_ptr_next, rd_addr;
  logic [MEM_WIDTH:0]          beat_last;
  logic [1:0]                  idx;
  logic [(DAC_LANES-1)*PS_WIDTH-1:0] pack;
  logic                        show, show_next, tail, tail_next, rd_en, start_load, held_show;
  logic [DAC_WIDTH-1:0]        rd_data;
  logic                        unused_inputs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_ctrl <= '0;
      trig_prev <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      gpio_ctrl <= gpio_ctrl_ext;
      trig_prev <= gpio_ctrl[GPIO_DAC_TRIGGER];
      trig_q    <= gpio_ctrl[GPIO_DAC_TRIGGER] & ~trig_prev;
    end
  end

  assign flush         = gpio_ctrl[GPIO_DAC_FLUSH];
  assign load_bit      = gpio_ctrl[GPIO_DAC_LOAD];
  assign loop_bit      = gpio_ctrl[GPIO_DAC_LOOP];
  assign fire          = trig_q & select_in;
  assign full          = (beat_count == FULL_COUNT);
  assign beat_last     = beat_count - COUNT_ONE;
  assign s_axis_tready = (state == LOAD) && load_bit && !flush && !full;
  assign handshake     = s_axis_tready && s_axis_tvalid;
  assign wr_en         = handshake && (idx == 2'd3);
  assign unused_inputs = ^{gpio_ctrl, m_axis_tready};

`ifdef DAC_HOLD_LAST_EN
  assign held_show = show;
`else
  assign held_show = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rd_ptr <= '0;
      show   <= 1'b0;
      tail   <= 1'b0;
    end else begin
      state  <= next_state;
      rd_ptr <= rd_ptr_next;
      show   <= show_next;
      tail   <= tail_next;
    end
  end

  // tail marks that the final non-looped beat is on the output; PLAY lasts one more cycle for it
  always_comb begin
    next_state  = state;
    rd_en       = 1'b0;
    rd_addr     = rd_ptr;
    rd_ptr_next = rd_ptr;
    show_next   = show;
    tail_next   = tail;
    start_load  = 1'b0;
    if (flush) begin
      next_state = IDLE;
      show_next  = 1'b0;
      tail_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          show_next = held_show;
          if (load_bit) begin
            next_state = LOAD;
            start_load = 1'b1;
          end else if (fire && beat_count != '0) begin
            next_state = PLAY;
            rd_en      = 1'b1;
            rd_addr    = '0;
          end
        end
        LOAD: begin
          show_next = held_show;
          if (!load_bit) next_state = IDLE;
        end
        PLAY: begin
          if (tail && !fire) begin
            next_state = IDLE;
            tail_next  = 1'b0;
            show_next  = held_show;
          end else begin
            rd_en   = 1'b1;
            rd_addr = fire ? '0 : rd_ptr;
          end
        end
        default: next_state = IDLE;
      endcase
    end
    if (rd_en) begin
      show_next   = 1'b1;
      tail_next   = 1'b0;
      rd_ptr_next = rd_addr + PTR_ONE;
      if ({1'b0, rd_addr} == beat_last) begin
        if (loop_bit) rd_ptr_next = '0;
        else          tail_next   = 1'b1;
      end
    end
  end

  // Lanes 0..2 are staged; the fourth word goes straight into the RAM write alongside them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      idx        <= 2'd0;
      pack       <= '0;
      beat_count <= '0;
    end else if (flush || start_load) begin
      wr_ptr     <= '0;
      idx        <= 2'd0;
      beat_count <= '0;
    end else if (state == LOAD && !load_bit) begin
      idx <= 2'd0;
    end else if (handshake) begin
      if (wr_en) begin
        idx        <= 2'd0;
        wr_ptr     <= wr_ptr + PTR_ONE;
        beat_count <= beat_count + COUNT_ONE;
      end else begin
        pack[idx*PS_WIDTH +: PS_WIDTH] <= s_axis_tdata;
        idx <= idx + 2'd1;
      end
    end
  end

  dac_wave_ram #(
    .ADDR_WIDTH(MEM_WIDTH),
    .DATA_WIDTH(DAC_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr),
    .wr_data({s_axis_tdata, pack}),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign m_axis_tdata  = show ? rd_data : '0;
  assign m_axis_tvalid = 1'b1;
  assign playing       = (state == PLAY);

endmodule
